// File: rtl/pipe_gen.sv
// pipe_gen: upstream column generator for the pipe pipeline.
// Emits one 8-bit column per scroll period (2^PERIOD_LOG2 clocks). Runs of
// empty columns alternate with pipe columns; each pipe has a GAP_ROWS-row
// opening whose vertical position comes from an internal 8-bit LFSR.
// Optional feature: define PIPE_GEN_FIXED_GAP_EN to force the gap to the top
// rows (deterministic bring-up); the LFSR keeps stepping either way.
module pipe_gen #(
  parameter int         PERIOD_LOG2 = 10,
  parameter int         SPACING     = 4,
  parameter int         PIPE_WIDTH  = 1,
  parameter int         GAP_ROWS    = 3,
  parameter logic [7:0] SEED        = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  output logic [7:0] location,
  output logic       col_strobe,
  output logic [7:0] pipes
);

  localparam int MAXTOP  = 8 - GAP_ROWS;
  localparam int CNT_MAX = (SPACING > PIPE_WIDTH) ? SPACING : PIPE_WIDTH;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic {ST_GAP = 1'b0, ST_PIPE = 1'b1} state_t;

  state_t                 r_state;
  logic [CNT_W-1:0]       r_col_cnt;
  logic [PERIOD_LOG2-1:0] r_div;
  logic [7:0]             r_lfsr;
  logic [7:0]             r_location;
  logic                   r_strobe;
  logic [7:0]             r_pipes;

  logic                   w_tick;
  logic [7:0]             w_lfsr_next;
  logic [2:0]             w_top;
  logic [7:0]             w_pattern;

  // Fibonacci step; taps 8,6,5,4 keep a nonzero state nonzero.
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // Column with rows top..top+GAP_ROWS-1 cleared; all other rows lit.
  function automatic logic [7:0] gap_pattern(input logic [2:0] top);
    logic [7:0] p;
    for (int b = 0; b < 8; b++) begin
      p[b] = !((b >= int'(top)) && (b < int'(top) + GAP_ROWS));
    end
    return p;
  endfunction

  // Pipe counter for scoring never wraps.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

`ifdef PIPE_GEN_FIXED_GAP_EN
  assign w_top = 3'd0;
`else
  // Fold out-of-range draws back into the legal range instead of redrawing,
  // so every pipe costs exactly one LFSR step.
  function automatic logic [2:0] fold_top(input logic [2:0] r);
    if (int'(r) > MAXTOP) return 3'(int'(r) - (MAXTOP + 1));
    return r;
  endfunction

  assign w_top = fold_top(w_lfsr_next[2:0]);
`endif

  assign w_tick      = run & (&r_div);
  assign w_lfsr_next = lfsr_step(r_lfsr);
  assign w_pattern   = gap_pattern(w_top);

  assign location   = r_location;
  assign col_strobe = r_strobe;
  assign pipes      = r_pipes;

  // Period divider, column strobe and GAP/PIPE sequencer, all advancing on tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_GAP;
      r_col_cnt  <= '0;
      r_div      <= '0;
      r_lfsr     <= SEED;
      r_location <= 8'h00;
      r_strobe   <= 1'b0;
      r_pipes    <= 8'h00;
    end else begin
      r_strobe <= w_tick;
      if (run) begin
        r_div <= r_div + PERIOD_LOG2'(1);
      end
      if (w_tick) begin
        case (r_state)
          ST_GAP: begin
            if (r_col_cnt == CNT_W'(SPACING - 1)) begin
              r_lfsr     <= w_lfsr_next;
              r_location <= w_pattern;
              r_col_cnt  <= '0;
              r_pipes    <= sat_inc(r_pipes);
              r_state    <= ST_PIPE;
            end else begin
              r_location <= 8'h00;
              r_col_cnt  <= r_col_cnt + CNT_W'(1);
            end
          end
          ST_PIPE: begin
            if (r_col_cnt == CNT_W'(PIPE_WIDTH - 1)) begin
              r_location <= 8'h00;
              r_col_cnt  <= '0;
              r_state    <= ST_GAP;
            end else begin
              r_col_cnt  <= r_col_cnt + CNT_W'(1);
            end
          end
          default: begin
            r_state <= ST_GAP;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_gen.sv
// tb_pipe_gen: randomized bench for pipe_gen with a tick/column reference model.
// Two instances share clock, reset and run: PIPE_WIDTH=1 (a) and PIPE_WIDTH=2 (b).
module tb_pipe_gen;

  localparam int P_LOG2 = 2;
  localparam int PER    = 1 << P_LOG2;
  localparam int SP     = 4;
  localparam int GAPR   = 3;
  localparam logic [7:0] SEED_V = 8'hA5;

`ifdef PIPE_GEN_FIXED_GAP_EN
  localparam logic [7:0] ANCH_P0 = 8'hF8;
  localparam logic [7:0] ANCH_P1 = 8'hF8;
`else
  localparam logic [7:0] ANCH_P0 = 8'hE3;
  localparam logic [7:0] ANCH_P1 = 8'h1F;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic [7:0] loc_a, loc_b, pipes_a, pipes_b;
  logic       strb_a, strb_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: active clocks and ticks since the last reset.
  int   active = 0;
  int   k = 0;
  logic tick = 1'b0;
  logic [7:0] pat_tbl [0:399];

  always #5 clk = ~clk;

  pipe_gen #(.PERIOD_LOG2(P_LOG2), .SPACING(SP), .PIPE_WIDTH(1), .GAP_ROWS(GAPR), .SEED(SEED_V))
    u_a (.clk(clk), .reset(reset), .run(run), .location(loc_a), .col_strobe(strb_a), .pipes(pipes_a));

  pipe_gen #(.PERIOD_LOG2(P_LOG2), .SPACING(SP), .PIPE_WIDTH(2), .GAP_ROWS(GAPR), .SEED(SEED_V))
    u_b (.clk(clk), .reset(reset), .run(run), .location(loc_b), .col_strobe(strb_b), .pipes(pipes_b));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (tick %0d, t=%0t)", tag, obs, exp, k, $time);
    end
  endtask

  // Pattern table: pipe j uses the LFSR value after j+1 steps from the seed.
  task automatic build_table();
    logic [7:0] s;
    int r, top, m;
    s = SEED_V;
    for (int j = 0; j < 400; j++) begin
      s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
      r = int'(s[2:0]);
      top = (r > 8 - GAPR) ? r - (8 - GAPR + 1) : r;
`ifdef PIPE_GEN_FIXED_GAP_EN
      top = 0;
`endif
      m = ((1 << GAPR) - 1) << top;
      pat_tbl[j] = 8'(255 & ~m);
    end
  endtask

  // Column shown after tick kk: first pipe on tick SP, then a cycle of
  // w pipe columns followed by SP empty columns.
  function automatic logic [7:0] exp_loc(input int kk, input int w);
    int q;
    if (kk < SP) return 8'h00;
    q = (kk - SP) % (SP + w);
    if (q < w) return pat_tbl[(kk - SP) / (SP + w)];
    return 8'h00;
  endfunction

  function automatic logic [7:0] exp_pipes(input int kk, input int w);
    int n;
    if (kk < SP) return 8'h00;
    n = (kk - SP) / (SP + w) + 1;
    return (n > 255) ? 8'hFF : 8'(n);
  endfunction

  // One clock with the given run/reset, then compare against the model.
  task automatic step(input logic rn, input logic rs);
    run = rn;
    reset = rs;
    @(posedge clk);
    #1;
    tick = 1'b0;
    if (rs) begin
      active = 0;
      k = 0;
    end else if (rn) begin
      active++;
      if (active % PER == 0) begin
        tick = 1'b1;
        k++;
      end
    end
    check_eq("loc_a",   {24'd0, loc_a},   {24'd0, exp_loc(k, 1)});
    check_eq("pipes_a", {24'd0, pipes_a}, {24'd0, exp_pipes(k, 1)});
    check_eq("strb_a",  {31'd0, strb_a},  {31'd0, tick});
    check_eq("loc_b",   {24'd0, loc_b},   {24'd0, exp_loc(k, 2)});
    check_eq("pipes_b", {24'd0, pipes_b}, {24'd0, exp_pipes(k, 2)});
    check_eq("strb_b",  {31'd0, strb_b},  {31'd0, tick});
    if (tick && k == 4) begin
      check_eq("tick4_loc",   {24'd0, loc_a},   {24'd0, ANCH_P0});
      check_eq("tick4_pipes", {24'd0, pipes_a}, 32'd1);
    end
    if (tick && k == 5) check_eq("w2_hold", {24'd0, loc_b}, {24'd0, ANCH_P0});
    if (tick && k == 9) begin
      check_eq("tick9_loc",   {24'd0, loc_a},   {24'd0, ANCH_P1});
      check_eq("tick9_pipes", {24'd0, pipes_a}, 32'd2);
    end
  endtask

  initial begin
    build_table();

    // Reset state
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check_eq("rst_loc",   {24'd0, loc_a},   32'd0);
    check_eq("rst_pipes", {24'd0, pipes_a}, 32'd0);
    check_eq("rst_strb",  {31'd0, strb_a},  32'd0);

    // First and second pipe with continuous run
    for (int i = 0; i < 38; i++) step(1'b1, 1'b0);

    // Run held low mid-period: nothing may move
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 24; i++) step(1'b1, 1'b0);

    // Reset on the cycle after tick 4 (pipe showing)
    step(1'b0, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0);
    check_eq("pre_rst_loc", {24'd0, loc_a}, {24'd0, ANCH_P0});
    step(1'b1, 1'b1);
    check_eq("midrst_loc",   {24'd0, loc_a},   32'd0);
    check_eq("midrst_pipes", {24'd0, pipes_a}, 32'd0);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0);

    // Random run gating
    for (int i = 0; i < 2000; i++) step(($urandom_range(0, 3) != 0), 1'b0);

    // Long run from reset into pipe-count saturation
    step(1'b0, 1'b1);
    for (int i = 0; i < 6300; i++) step(1'b1, 1'b0);
    check_eq("sat_a", {24'd0, pipes_a}, 32'd255);
    check_eq("sat_b", {24'd0, pipes_b}, 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
